// File: rtl/rc4_pkg.sv
// rc4_pkg: shared state/phase types and S-RAM geometry for the RC4 key-search controller
package rc4_pkg;
   localparam int DEF_KEY_WIDTH = 24;
   localparam int S_DEPTH = 256;
   localparam int S_AW = $clog2(S_DEPTH);
   typedef enum logic [3:0] {
      IDLE, RST_INIT, INIT, RST_SHUF, SHUF, RST_DEC, DEC, NEXT_KEY, FOUND, FAIL
   } ctrl_state_t;
   typedef enum logic [1:0] {PH_NONE, PH_INIT, PH_SHUF, PH_DEC} phase_t;
   // A phase owns the RAM from its reset cycle onward, so the sub-FSM sees its
   // own port the moment it leaves reset.
   function automatic phase_t state_phase(input ctrl_state_t s);
      return (s == RST_INIT || s == INIT) ? PH_INIT :
             (s == RST_SHUF || s == SHUF) ? PH_SHUF :
             (s == RST_DEC  || s == DEC)  ? PH_DEC  : PH_NONE;
   endfunction
endpackage

// File: rtl/s_ram_port_mux.sv
// s_ram_port_mux: combinational 3:1 grant of the single S-RAM port to the active phase
//   phase                 : selects init / shuffle / decrypt requester, PH_NONE parks the port
//   init_* / shuf_* / dec_* : requester address, write data, write enable
//   ram_*                 : S-RAM port (all zero when no phase is active)
module s_ram_port_mux
   import rc4_pkg::*;
(
   input  phase_t          phase,
   input  logic [S_AW-1:0] init_address,
   input  logic [7:0]      init_data,
   input  logic            init_wren,
   input  logic [S_AW-1:0] shuf_address,
   input  logic [7:0]      shuf_data,
   input  logic            shuf_wren,
   input  logic [S_AW-1:0] dec_address,
   input  logic [7:0]      dec_data,
   input  logic            dec_wren,
   output logic [S_AW-1:0] ram_address,
   output logic [7:0]      ram_data,
   output logic            ram_wren
);
   assign ram_address = phase == PH_INIT ? init_address :
                        phase == PH_SHUF ? shuf_address :
                        phase == PH_DEC  ? dec_address  : '0;
   assign ram_data    = phase == PH_INIT ? init_data :
                        phase == PH_SHUF ? shuf_data :
                        phase == PH_DEC  ? dec_data  : '0;
   assign ram_wren    = phase == PH_INIT ? init_wren :
                        phase == PH_SHUF ? shuf_wren :
                        phase == PH_DEC  ? dec_wren  : 1'b0;
endmodule

// File: rtl/rc4_search_ctrl.sv
// rc4_search_ctrl: sequences init/shuffle/decrypt per candidate key and owns the S-RAM port
//   clk, reset (async, active-low), start (level, honoured only when not busy)
//   secret_key                         : current candidate key
//   sub_reset_n, *_start               : registered controls to the phase sub-FSMs
//   *_done, decrypt_valid              : phase status (done only honoured for the active phase)
//   init_* / shuf_* / dec_*            : requester RAM ports, ram_* : granted S-RAM port
//   busy, key_found, key_fail          : search status
module rc4_search_ctrl
   import rc4_pkg::*;
#(
   parameter int KEY_WIDTH = DEF_KEY_WIDTH,
   parameter logic [KEY_WIDTH-1:0] KEY_START = '0,
   parameter logic [KEY_WIDTH-1:0] KEY_MAX = KEY_WIDTH'(24'h3FFFFF)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   output logic [KEY_WIDTH-1:0] secret_key,
   output logic                 sub_reset_n,
   output logic                 init_start,
   output logic                 shuffle_start,
   output logic                 decrypt_start,
   input  logic                 init_done,
   input  logic                 shuffle_done,
   input  logic                 decrypt_done,
   input  logic                 decrypt_valid,
   input  logic [S_AW-1:0]      init_address,
   input  logic [7:0]           init_data,
   input  logic                 init_wren,
   input  logic [S_AW-1:0]      shuf_address,
   input  logic [7:0]           shuf_data,
   input  logic                 shuf_wren,
   input  logic [S_AW-1:0]      dec_address,
   input  logic [7:0]           dec_data,
   input  logic                 dec_wren,
   output logic [S_AW-1:0]      ram_address,
   output logic [7:0]           ram_data,
   output logic                 ram_wren,
   output logic                 busy,
   output logic                 key_found,
   output logic                 key_fail
);
   ctrl_state_t state, state_nx;
   logic at_rest, at_rest_nx;
   assign at_rest    = state == IDLE || state == FOUND || state == FAIL;
   assign at_rest_nx = state_nx == IDLE || state_nx == FOUND || state_nx == FAIL;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, FOUND, FAIL: state_nx = start ? RST_INIT : state;
         RST_INIT:          state_nx = INIT;
         INIT:              state_nx = init_done ? RST_SHUF : INIT;
         RST_SHUF:          state_nx = SHUF;
         SHUF:              state_nx = shuffle_done ? RST_DEC : SHUF;
         RST_DEC:           state_nx = DEC;
         DEC:               state_nx = !decrypt_done ? DEC :
                                       decrypt_valid ? FOUND :
                                       secret_key == KEY_MAX ? FAIL : NEXT_KEY;
         NEXT_KEY:          state_nx = RST_INIT;
         default:           state_nx = IDLE;
      endcase
   end
   // Phase controls are registered from the current state, so each start rises
   // one cycle after its one-cycle sub_reset_n pulse; status flags track state_nx
   // so they line up with the state itself.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         secret_key    <= KEY_START;
         sub_reset_n   <= 1'b0;
         init_start    <= 1'b0;
         shuffle_start <= 1'b0;
         decrypt_start <= 1'b0;
         busy          <= 1'b0;
         key_found     <= 1'b0;
         key_fail      <= 1'b0;
      end else begin
         state         <= state_nx;
         if (at_rest && start)
            secret_key <= KEY_START;
         else if (state == NEXT_KEY)
            secret_key <= secret_key + KEY_WIDTH'(1);
         sub_reset_n   <= !(state == RST_INIT || state == RST_SHUF || state == RST_DEC);
         init_start    <= state == INIT;
         shuffle_start <= state == SHUF;
         decrypt_start <= state == DEC;
         busy          <= !at_rest_nx;
         key_found     <= state_nx == FOUND;
         key_fail      <= state_nx == FAIL;
      end
   end
   s_ram_port_mux u_mux (
      .phase        (state_phase(state)),
      .init_address (init_address),
      .init_data    (init_data),
      .init_wren    (init_wren),
      .shuf_address (shuf_address),
      .shuf_data    (shuf_data),
      .shuf_wren    (shuf_wren),
      .dec_address  (dec_address),
      .dec_data     (dec_data),
      .dec_wren     (dec_wren),
      .ram_address  (ram_address),
      .ram_data     (ram_data),
      .ram_wren     (ram_wren)
   );
endmodule

// File: tb/tb_rc4_search_ctrl.sv
// tb_rc4_search_ctrl: directed self-checking bench for rc4_search_ctrl with KEY_MAX=3
module tb_rc4_search_ctrl;
   localparam int KW = 24;
   localparam logic [31:0] RAM_I = {15'd0, 1'b1, 8'hA1, 8'h11};
   localparam logic [31:0] RAM_S = {15'd0, 1'b1, 8'hB2, 8'h22};
   localparam logic [31:0] RAM_D = {15'd0, 1'b1, 8'hC3, 8'h33};
   typedef struct {
      logic          ven;
      logic [KW-1:0] vkey;
      logic          exp_found;
      logic          exp_fail;
      logic [KW-1:0] exp_key;
      int            exp_att;
   } vec_t;
   logic clk = 1'b0, reset = 1'b0, start = 1'b0;
   logic [KW-1:0] secret_key;
   logic sub_reset_n, init_start, shuffle_start, decrypt_start;
   logic init_done, shuffle_done, decrypt_done, decrypt_valid;
   logic [7:0] ram_address, ram_data;
   logic ram_wren, busy, key_found, key_fail;
   logic valid_en = 1'b0, inj = 1'b0;
   logic [KW-1:0] valid_key = '0;
   logic [2:0] ic = '0, sc = '0, dc = '0;
   int n_cmp = 0, n_bad = 0;
   vec_t vecs[4];
   rc4_search_ctrl #(.KEY_WIDTH(KW), .KEY_START(24'h0), .KEY_MAX(24'h3)) dut (
      .clk(clk), .reset(reset), .start(start), .secret_key(secret_key),
      .sub_reset_n(sub_reset_n), .init_start(init_start), .shuffle_start(shuffle_start),
      .decrypt_start(decrypt_start), .init_done(init_done), .shuffle_done(shuffle_done),
      .decrypt_done(decrypt_done), .decrypt_valid(decrypt_valid),
      .init_address(8'h11), .init_data(8'hA1), .init_wren(1'b1),
      .shuf_address(8'h22), .shuf_data(8'hB2), .shuf_wren(1'b1),
      .dec_address(8'h33), .dec_data(8'hC3), .dec_wren(1'b1),
      .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
      .busy(busy), .key_found(key_found), .key_fail(key_fail)
   );
   always #5 clk = ~clk;
   // Sub-FSM stand-ins: done rises 5 cycles after their start, cleared by sub_reset_n.
   always @(posedge clk) begin
      ic <= !sub_reset_n ? 3'd0 : (init_start && ic < 3'd5) ? ic + 3'd1 : ic;
      sc <= !sub_reset_n ? 3'd0 : (shuffle_start && sc < 3'd5) ? sc + 3'd1 : sc;
      dc <= !sub_reset_n ? 3'd0 : (decrypt_start && dc < 3'd5) ? dc + 3'd1 : dc;
   end
   assign init_done     = ic == 3'd5;
   assign shuffle_done  = sc == 3'd5 || inj;
   assign decrypt_done  = dc == 3'd5 || inj;
   assign decrypt_valid = valid_en && secret_key == valid_key;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_idle(output int att, output bit ok);
      int a = 0;
      bit prev = init_start;
      ok = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (init_start && !prev) a++;
         prev = init_start;
         if (!busy) chk("ram_parked", {15'd0, ram_wren, ram_data, ram_address}, 32'd0);
         else if (init_start && !init_done) chk("ram_init", {15'd0, ram_wren, ram_data, ram_address}, RAM_I);
         else if (shuffle_start && !shuffle_done) chk("ram_shuf", {15'd0, ram_wren, ram_data, ram_address}, RAM_S);
         else if (decrypt_start && !decrypt_done) chk("ram_dec", {15'd0, ram_wren, ram_data, ram_address}, RAM_D);
         if (!busy) begin
            ok = 1'b1;
            break;
         end
      end
      att = a;
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   initial begin
      int att;
      bit ok;
      vecs[0] = '{1'b1, 24'd2, 1'b1, 1'b0, 24'd2, 3};
      vecs[1] = '{1'b0, 24'd0, 1'b0, 1'b1, 24'd3, 4};
      vecs[2] = '{1'b1, 24'd0, 1'b1, 1'b0, 24'd0, 1};
      vecs[3] = '{1'b1, 24'd3, 1'b1, 1'b0, 24'd3, 4};
      #12;
      chk("rst_key", 32'(secret_key), 32'd0);
      chk("rst_ctrl", {28'd0, sub_reset_n, init_start, shuffle_start, decrypt_start}, 32'd0);
      chk("rst_status", {29'd0, busy, key_found, key_fail}, 32'd0);
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      chk("rel_sub_reset_n", 32'(sub_reset_n), 32'd1);
      chk("rel_busy", 32'(busy), 32'd0);
      chk("idle_ram", {15'd0, ram_wren, ram_data, ram_address}, 32'd0);
      // Cycle-accurate first attempt: key 0 fails, spurious shuffle/decrypt done during INIT.
      valid_en = 1'b1;
      valid_key = 24'd2;
      @(negedge clk) start = 1'b1;
      for (int k = 0; k < 28; k++) begin
         logic [3:0] ctl;
         logic [31:0] rm;
         @(negedge clk);
         if (k == 0) start = 1'b0;
         ctl = {!(k == 1 || k == 9 || k == 17 || k == 26),
                (k >= 2 && k <= 8) || k == 27, k >= 10 && k <= 16, k >= 18 && k <= 24};
         rm = k == 24 ? 32'd0 : (k <= 7 || k >= 25) ? RAM_I : k <= 15 ? RAM_S : RAM_D;
         chk($sformatf("tl_ctrl[%0d]", k), {28'd0, sub_reset_n, init_start, shuffle_start, decrypt_start}, {28'd0, ctl});
         chk($sformatf("tl_ram[%0d]", k), {15'd0, ram_wren, ram_data, ram_address}, rm);
         chk($sformatf("tl_key[%0d]", k), 32'(secret_key), k >= 25 ? 32'd1 : 32'd0);
         if (k == 2) inj = 1'b1;
         if (k == 6) inj = 1'b0;
      end
      wait_idle(att, ok);
      chk("tl_done", 32'(ok), 32'd1);
      chk("tl_found", 32'(key_found), 32'd1);
      chk("tl_key_final", 32'(secret_key), 32'd2);
      chk("tl_att", 32'(att), 32'd1);
      // Whole-search vectors.
      for (int i = 0; i < 4; i++) begin
         valid_en = vecs[i].ven;
         valid_key = vecs[i].vkey;
         pulse_start();
         chk($sformatf("v%0d_key_restart", i), 32'(secret_key), 32'd0);
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
         wait_idle(att, ok);
         chk($sformatf("v%0d_done", i), 32'(ok), 32'd1);
         chk($sformatf("v%0d_found", i), 32'(key_found), 32'(vecs[i].exp_found));
         chk($sformatf("v%0d_fail", i), 32'(key_fail), 32'(vecs[i].exp_fail));
         chk($sformatf("v%0d_key", i), 32'(secret_key), 32'(vecs[i].exp_key));
         chk($sformatf("v%0d_attempts", i), 32'(att), 32'(vecs[i].exp_att));
         repeat (5) @(negedge clk);
         chk($sformatf("v%0d_key_hold", i), 32'(secret_key), 32'(vecs[i].exp_key));
         chk($sformatf("v%0d_ctrl_quiet", i), {29'd0, init_start, shuffle_start, decrypt_start}, 32'd0);
      end
      // Reset during SHUF on key 1 aborts; a new start begins again from key 0.
      valid_en = 1'b0;
      pulse_start();
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (shuffle_start && secret_key == 24'd1) begin
            ok = 1'b1;
            break;
         end
      end
      chk("abort_reached_shuf_k1", 32'(ok), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("abort_key", 32'(secret_key), 32'd0);
      chk("abort_ctrl", {28'd0, sub_reset_n, init_start, shuffle_start, decrypt_start}, 32'd0);
      chk("abort_status", {29'd0, busy, key_found, key_fail}, 32'd0);
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      chk("abort_rel_sub_reset_n", 32'(sub_reset_n), 32'd1);
      chk("abort_rel_busy", 32'(busy), 32'd0);
      valid_en = 1'b1;
      valid_key = 24'd2;
      pulse_start();
      chk("rerun_key0", 32'(secret_key), 32'd0);
      wait_idle(att, ok);
      chk("rerun_done", 32'(ok), 32'd1);
      chk("rerun_found", 32'(key_found), 32'd1);
      chk("rerun_key", 32'(secret_key), 32'd2);
      chk("rerun_attempts", 32'(att), 32'd3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
